fp_adder_pipe: RTL and testbench
================================

FP_ADDER_PIPE -- requirements
Module: fp_adder_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23, stored mantissa field width; data width W = 1+EXP_W+MAN_W.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port x_rdy  input  1  x_data valid.
REQ-006 SHALL have port y_rdy  input  1  y_data valid.
REQ-007 SHALL have port x_data  input  W  operand x, IEEE-754 layout {sign, exp, man}.
REQ-008 SHALL have port y_data  input  W  operand y, same layout.
REQ-009 SHALL have port sub  input  1  mode: 0 = x+y, 1 = x-y; sampled with operands.
REQ-010 SHALL have port in_ack  output  1  operands accepted this cycle.
REQ-011 SHALL have port z_data  output  W  result.
REQ-012 SHALL have port done  output  1  z_data valid.
REQ-013 SHALL have port z_ack  input  1  consumer takes z_data.

Function
REQ-014 Operand transfer SHALL occur on a rising edge where x_rdy && y_rdy && in_ack; either rdy alone transfers nothing.
REQ-015 Pipeline SHALL have 3 stages: S1 unpack/classify/swap/align, S2 signed mantissa add/subtract, S3 normalise/round/pack.
REQ-016 Latency SHALL be 3 cycles: operands accepted at edge n give done=1 with result after edge n+3 when unstalled.
REQ-017 Throughput SHALL be one operation per cycle when z_ack is held high.
REQ-018 Stall SHALL occur when done && !z_ack: all stages hold, in_ack=0, z_data stable.
REQ-019 in_ack SHALL equal !(done && !z_ack); bubbles SHALL advance and be squeezed out only behind a non-stalled output.
REQ-020 done SHALL drop after the edge where z_ack=1 unless a new result advances into S3 the same edge.
REQ-021 Rounding SHALL be round-to-nearest-even using guard, round and sticky bits; sticky SHALL OR all bits shifted out during alignment.
REQ-022 Alignment shift of MAN_W+3 or more SHALL leave only sticky from the smaller operand.
REQ-023 Subnormal inputs SHALL be flushed to signed zero; subnormal results SHALL flush to +0.
REQ-024 Zero operand SHALL return the other operand bit-exact (sign adjusted for sub); +0 + -0 = +0; -0 + -0 = -0.
REQ-025 Exact cancellation (x + -x) SHALL return +0.
REQ-026 Exponent overflow after rounding SHALL return signed infinity.
REQ-027 Any NaN input, or inf + -inf, SHALL return canonical quiet NaN {0, all-ones exp, 1, zeros} (0x7FC00000 at defaults).
REQ-028 Single infinity input SHALL return that infinity (sign adjusted for sub).
REQ-029 Rounding carry into hidden bit SHALL increment exponent and renormalise.

Reset
REQ-030 While rst=1 all stage-valid flags, done and z_data SHALL be 0 immediately, independent of clk.
REQ-031 in_ack SHALL be 1 during and after reset; operations in flight at reset SHALL be discarded, never emitted.
REQ-032 First transfer after rst falls SHALL be the first rising edge with rst=0 and both rdy high.

Structure
REQ-033 Shared package fp_pkg SHALL hold default EXP_W/MAN_W, exponent bias function, canonical NaN and infinity constants, and class encoding (ZERO, NORM, INF, NAN).
REQ-034 Leading-zero counter SHALL be a sub-module fp_lzc, parameterised by width, used in S3.
REQ-035 No multi-cycle paths; every stage SHALL be fully registered.

Verification
REQ-036 x=0x40033333, y=0x00000000, sub=0 -> z=0x40033333, done 3 cycles after transfer.
REQ-037 x=0x00000000, y=0x3F828F5C -> z=0x3F828F5C; x=0x40033333, y=0x3F828F5C -> z=0x40447AE1.
REQ-038 x=0x3F800000, y=0x3F800000, sub=1 -> z=0x00000000; x=0x7F7FFFFF + 0x7F7FFFFF -> z=0x7F800000.
REQ-039 x=0x7F800000, y=0xFF800000 -> z=0x7FC00000; x=0x00000001 + 0x3F800000 -> z=0x3F800000.
REQ-040 Stream 8 back-to-back ops, z_ack low 4 cycles mid-stream -> in_ack low, z_data stable, all 8 results in order, none lost or duplicated.
REQ-041 Assert rst with 3 ops in flight -> done=0 immediately, no stale result after release; next op returns correct z in 3 cycles.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared constants, class encoding and helpers for the pipelined FP adder.
package fp_pkg;

    localparam int EXP_W_DEF = 8;
    localparam int MAN_W_DEF = 23;

    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_NORM,
        CLS_INF,
        CLS_NAN
    } fp_cls_t;

    localparam logic [31:0] QNAN_SP = 32'h7FC0_0000;
    localparam logic [31:0] INF_SP  = 32'h7F80_0000;

    function automatic int exp_bias(input int ew);
        return (1 << (ew - 1)) - 1;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter; returns WIDTH when the input is all zeros.
module fp_lzc #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]             bits,
    output logic [$clog2(WIDTH+1)-1:0]   count
);
    localparam int CW = $clog2(WIDTH + 1);

    // Scanning upward lets the highest set bit win.
    always_comb begin
        count = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (bits[i]) count = CW'(WIDTH - 1 - i);
        end
    end
endmodule

// File: rtl/fp_adder_pipe.sv
// Pipelined IEEE-754 style adder/subtractor: input register, then
// align (S1), add (S2), normalise/round/pack (S3).
module fp_adder_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     x_rdy,
    input  logic                     y_rdy,
    input  logic [EXP_W+MAN_W:0]     x_data,
    input  logic [EXP_W+MAN_W:0]     y_data,
    input  logic                     sub,
    output logic                     in_ack,
    output logic [EXP_W+MAN_W:0]     z_data,
    output logic                     done,
    input  logic                     z_ack
);
    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int MX   = MAN_W + 4;
    localparam int LZW  = $clog2(MX + 1);
    localparam int EMAX = 2 * exp_bias(EXP_W) + 1;
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [W-1:0] INF  = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};

    function automatic fp_cls_t classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
        if (e == '0) return CLS_ZERO;
        if (e == '1) return (m == '0) ? CLS_INF : CLS_NAN;
        return CLS_NORM;
    endfunction

    logic adv;
    assign adv    = !(done && !z_ack);
    assign in_ack = adv;

    // Input register
    logic         v0, sub_r;
    logic [W-1:0] xr, yr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v0 <= 1'b0; xr <= '0; yr <= '0; sub_r <= 1'b0;
        end else if (adv) begin
            v0 <= x_rdy && y_rdy;
            xr <= x_data; yr <= y_data; sub_r <= sub;
        end
    end

    // S1: classify, swap larger magnitude into a, align b
    logic             xs, ys, swap, sp1, as1;
    logic [EXP_W-1:0] xe, ye, ae, be, d;
    logic [MAN_W-1:0] xm, ym, am, bm;
    logic [MX-1:0]    bext, bal;
    logic [W-1:0]     spv1;
    fp_cls_t          xc, yc;

    assign xs = xr[W-1];
    assign ys = yr[W-1] ^ sub_r;
    assign xe = xr[W-2:MAN_W];
    assign ye = yr[W-2:MAN_W];
    assign xm = xr[MAN_W-1:0];
    assign ym = yr[MAN_W-1:0];
    assign xc = classify(xe, xm);
    assign yc = classify(ye, ym);

    always_comb begin
        swap = {ye, ym} > {xe, xm};
        ae   = swap ? ye : xe;
        be   = swap ? xe : ye;
        am   = swap ? ym : xm;
        bm   = swap ? xm : ym;
        as1  = swap ? ys : xs;
        d    = ae - be;
        bext = {1'b1, bm, 3'b000};
        if (int'(d) >= MAN_W + 3) begin
            bal = {{(MX-1){1'b0}}, 1'b1};
        end else begin
            bal    = bext >> d;
            bal[0] = bal[0] | (|(bext & ~({MX{1'b1}} << d)));
        end
        sp1  = 1'b1;
        spv1 = '0;
        priority case (1'b1)
            xc == CLS_NAN || yc == CLS_NAN: spv1 = QNAN;
            xc == CLS_INF && yc == CLS_INF: spv1 = (xs != ys) ? QNAN : {xs, INF[W-2:0]};
            xc == CLS_INF:                  spv1 = {xs, INF[W-2:0]};
            yc == CLS_INF:                  spv1 = {ys, INF[W-2:0]};
            xc == CLS_ZERO && yc == CLS_ZERO: spv1 = {xs && ys, {(W-1){1'b0}}};
            xc == CLS_ZERO:                 spv1 = {ys, yr[W-2:0]};
            yc == CLS_ZERO:                 spv1 = xr;
            default:                        sp1  = 1'b0;
        endcase
    end

    logic             v1, s1_sp, s1_sign, s1_sub;
    logic [W-1:0]     s1_spv;
    logic [EXP_W-1:0] s1_exp;
    logic [MX-1:0]    s1_a, s1_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0; s1_sp <= 1'b0; s1_spv <= '0; s1_sign <= 1'b0;
            s1_sub <= 1'b0; s1_exp <= '0; s1_a <= '0; s1_b <= '0;
        end else if (adv) begin
            v1 <= v0; s1_sp <= sp1; s1_spv <= spv1; s1_sign <= as1;
            s1_sub <= xs ^ ys; s1_exp <= ae;
            s1_a <= {1'b1, am, 3'b000}; s1_b <= bal;
        end
    end

    // S2: magnitude add/subtract; a >= b so the difference is never negative
    logic             v2, s2_sp, s2_sign;
    logic [W-1:0]     s2_spv;
    logic [EXP_W-1:0] s2_exp;
    logic [MX:0]      s2_sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2 <= 1'b0; s2_sp <= 1'b0; s2_spv <= '0; s2_sign <= 1'b0;
            s2_exp <= '0; s2_sum <= '0;
        end else if (adv) begin
            v2 <= v1; s2_sp <= s1_sp; s2_spv <= s1_spv; s2_sign <= s1_sign;
            s2_exp <= s1_exp;
            s2_sum <= s1_sub ? {1'b0, s1_a} - {1'b0, s1_b} : {1'b0, s1_a} + {1'b0, s1_b};
        end
    end

    // S3: normalise, round to nearest even, pack
    logic [LZW-1:0]   lz;
    logic [MX-1:0]    n;
    logic [EXP_W+1:0] e;
    logic [MAN_W+1:0] mr;
    logic [MAN_W-1:0] frac;
    logic             rnd;
    logic [W-1:0]     z_n;

    fp_lzc #(.WIDTH(MX)) u_lzc (
        .bits  (s2_sum[MX-1:0]),
        .count (lz)
    );

    always_comb begin
        if (s2_sum[MX]) begin
            n = {s2_sum[MX:2], s2_sum[1] | s2_sum[0]};
            e = {2'b00, s2_exp} + (EXP_W+2)'(1);
        end else begin
            n = s2_sum[MX-1:0] << lz;
            e = {2'b00, s2_exp} - (EXP_W+2)'(lz);
        end
        rnd = n[2] && (n[1] || n[0] || n[3]);
        mr  = {1'b0, n[MX-1:3]} + (MAN_W+2)'(rnd);
        if (mr[MAN_W+1]) begin
            e    = e + (EXP_W+2)'(1);
            frac = '0;
        end else begin
            frac = mr[MAN_W-1:0];
        end
        if (s2_sp)
            z_n = s2_spv;
        else if (s2_sum == '0 || e[EXP_W+1] || e == '0)
            z_n = '0;
        else if (e[EXP_W:0] >= (EXP_W+1)'(EMAX))
            z_n = {s2_sign, INF[W-2:0]};
        else
            z_n = {s2_sign, e[EXP_W-1:0], frac};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done   <= 1'b0;
            z_data <= '0;
        end else if (adv) begin
            done <= v2;
            if (v2) z_data <= z_n;
        end
    end

endmodule

// File: tb/tb_fp_adder_pipe.sv
// Directed bench for fp_adder_pipe: single ops with latency, handshake,
// a stalled stream and a reset with operations in flight.
module tb_fp_adder_pipe;
    import fp_pkg::*;

    logic        clk = 1'b0;
    logic        rst, x_rdy, y_rdy, sub, z_ack;
    logic        in_ack, done;
    logic [31:0] x_data, y_data, z_data;

    int n_tests = 0;
    int n_fail  = 0;

    localparam int NV = 20;
    logic [31:0] vx [NV] = '{
        32'h40033333, 32'h00000000, 32'h40033333, 32'h3F800000, 32'h7F7FFFFF,
        32'h7F800000, 32'h00000001, 32'h80000000, 32'h00000000, 32'h00000000,
        32'h3F800000, 32'h3F800001, 32'h3F800000, 32'h3F800000, 32'h3FFFFFFF,
        32'h3F800000, 32'h00800000, 32'h7F800001, 32'h3F800000, 32'hC0000000};
    logic [31:0] vy [NV] = '{
        32'h00000000, 32'h3F828F5C, 32'h3F828F5C, 32'h3F800000, 32'h7F7FFFFF,
        32'hFF800000, 32'h3F800000, 32'h80000000, 32'h80000000, 32'h3F800000,
        32'h33800000, 32'h33800000, 32'h33800001, 32'h33800000, 32'h33800000,
        32'h30800000, 32'h00800001, 32'h3F800000, 32'h7F800000, 32'h3F800000};
    logic        vs [NV] = '{
        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] vz [NV] = '{
        32'h40033333, 32'h3F828F5C, 32'h40447AE1, 32'h00000000, INF_SP,
        QNAN_SP,      32'h3F800000, 32'h80000000, 32'h00000000, 32'hBF800000,
        32'h3F800000, 32'h3F800002, 32'h3F800001, 32'h3F7FFFFF, 32'h40000000,
        32'h3F800000, 32'h00000000, QNAN_SP,      32'hFF800000, 32'hBF800000};

    logic [31:0] sx [8] = '{
        32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
        32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    logic [31:0] sz [8] = '{
        32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
        32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000};

    always #5 clk = ~clk;

    fp_adder_pipe dut (
        .clk    (clk),
        .rst    (rst),
        .x_rdy  (x_rdy),
        .y_rdy  (y_rdy),
        .x_data (x_data),
        .y_data (y_data),
        .sub    (sub),
        .in_ack (in_ack),
        .z_data (z_data),
        .done   (done),
        .z_ack  (z_ack)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [31:0] exp, input string tag);
        @(negedge clk);
        x_data = a; y_data = b; sub = s;
        x_rdy = 1'b1; y_rdy = 1'b1; z_ack = 1'b1;
        #1 check({tag, " in_ack"}, 32'(in_ack), 32'd1);
        @(negedge clk);
        x_rdy = 1'b0; y_rdy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check({tag, " early done"}, 32'(done), 32'd0);
        @(negedge clk);
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " z"}, z_data, exp);
    endtask

    task automatic present(input int k);
        x_data = sx[k]; y_data = 32'h3F800000; sub = 1'b0;
        x_rdy = 1'b1; y_rdy = 1'b1;
    endtask

    task automatic stream_test();
        int          wr = 0;
        int          rd = 0;
        int          c  = 0;
        bit          pending, stall;
        bit          prev_stall = 0;
        logic [31:0] last_z = '0;
        @(negedge clk);
        present(0);
        while (rd < 8 && c < 60) begin
            z_ack = !(c >= 5 && c <= 8);
            #1;
            if (done && z_ack) begin
                check($sformatf("stream z%0d", rd), z_data, sz[rd]);
                rd++;
            end
            stall = done && !z_ack;
            if (stall) begin
                check("stall in_ack", 32'(in_ack), 32'd0);
                if (prev_stall) check("stall z hold", z_data, last_z);
            end
            prev_stall = stall;
            last_z     = z_data;
            pending    = x_rdy && y_rdy && in_ack;
            @(negedge clk);
            c++;
            if (pending) begin
                wr++;
                if (wr < 8) present(wr);
                else begin
                    x_rdy = 1'b0; y_rdy = 1'b0;
                end
            end
        end
        check("stream results", 32'(rd), 32'd8);
        check("stream sent", 32'(wr), 32'd8);
        z_ack = 1'b1;
        #1 check("stream no dup", 32'(done), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; x_rdy = 1'b0; y_rdy = 1'b0; sub = 1'b0; z_ack = 1'b1;
        x_data = '0; y_data = '0;
        #1;
        check("reset done", 32'(done), 32'd0);
        check("reset z", z_data, 32'd0);
        check("reset in_ack", 32'(in_ack), 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++)
            run_op(vx[i], vy[i], vs[i], vz[i], $sformatf("v%0d", i));

        // one-sided readiness must never transfer
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            x_data = 32'h3F800000; y_data = 32'h3F800000; sub = 1'b0;
            x_rdy = (i < 3); y_rdy = (i >= 3 && i < 6);
            #1 check($sformatf("lone rdy %0d", i), 32'(done), 32'd0);
        end
        x_rdy = 1'b0; y_rdy = 1'b0;

        stream_test();

        // reset with three operations in flight
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            present(i);
        end
        @(negedge clk);
        x_rdy = 1'b0; y_rdy = 1'b0;
        @(negedge clk);
        check("pre-reset done", 32'(done), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async rst done", 32'(done), 32'd0);
        check("async rst z", z_data, 32'd0);
        check("async rst in_ack", 32'(in_ack), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("post-rst stale %0d", i), 32'(done), 32'd0);
        end
        run_op(vx[2], vy[2], vs[2], vz[2], "post-rst op");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
